// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Decode-stage register file with write-to-read bypass, a power-up clear
// sequencer and a per-register pending scoreboard for hazard detection.
//
// Ports
//   clk        clock; every state update happens on its rising edge
//   rst        synchronous active-high reset; restarts the clear sequence
//   wena       write enable (writeback); also retires the pending bit
//   waddr      write address
//   wdata      write data
//   raddr      NUM_RD packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata      NUM_RD packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   pend_set   mark pend_addr pending (instruction issued)
//   pend_addr  register to mark pending
//   rd_pend    per-read-port hazard flag
//   pend       raw scoreboard vector, one bit per register
//   init_busy  high while the clear sequence runs
//
// Build option
//   REG_FILE_ZERO_REG_EN  when defined, entry 0 is hardwired to zero: writes
//                         to it are dropped, reads return 0 without bypass,
//                         and it can never be marked pending.
// ---------------------------------------------------------------------------
module reg_file_sb #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_RD     = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wena,
   input  logic [ADDR_WIDTH-1:0]          waddr,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
   input  logic                           pend_set,
   input  logic [ADDR_WIDTH-1:0]          pend_addr,
   output logic [NUM_RD-1:0]              rd_pend,
   output logic [(2**ADDR_WIDTH)-1:0]     pend,
   output logic                           init_busy
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef enum logic {INIT, RUN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   initCnt_q, initCnt_d;
   logic [DEPTH-1:0]        pend_q, pend_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    memWe;
   logic [ADDR_WIDTH-1:0]   memAddr;
   logic [DATA_WIDTH-1:0]   memData;
   logic                    running;
   logic                    writeAllowed;
   logic                    setAllowed;

   assign running   = (state_q == RUN);
   assign init_busy = (state_q == INIT);
   assign pend      = pend_q;

`ifdef REG_FILE_ZERO_REG_EN
   assign writeAllowed = (waddr != '0);
   assign setAllowed   = (pend_addr != '0);
`else
   assign writeAllowed = 1'b1;
   assign setAllowed   = 1'b1;
`endif

   // Next-state logic. In INIT the single memory write port is borrowed by
   // the clear sequencer, so user writes and issue marks are simply not
   // looked at. In RUN the clear of the retiring register is applied before
   // the set of the newly issued one, so a same-address collision leaves the
   // bit set for the new producer.
   always_comb begin
      state_d   = state_q;
      initCnt_d = initCnt_q;
      pend_d    = pend_q;
      memWe     = 1'b0;
      memAddr   = waddr;
      memData   = wdata;
      case (state_q)
         INIT: begin
            memWe     = 1'b1;
            memAddr   = initCnt_q;
            memData   = '0;
            initCnt_d = initCnt_q + ADDR_WIDTH'(1);
            if (initCnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (wena) begin
               memWe          = writeAllowed;
               pend_d[waddr]  = 1'b0;
            end
            if (pend_set && setAllowed) begin
               pend_d[pend_addr] = 1'b1;
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // Control state. Reset holds the sequencer at the start of the clear and
   // wipes the scoreboard; the storage array itself is cleared by INIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT;
         initCnt_q <= '0;
         pend_q    <= '0;
      end else begin
         state_q   <= state_d;
         initCnt_q <= initCnt_d;
         pend_q    <= pend_d;
      end
   end

   // Storage array. Kept reset-free so it maps onto plain RAM/flops; no write
   // happens during a reset cycle so an aborted sequence restarts cleanly.
   always_ff @(posedge clk) begin
      if (!rst && memWe) begin
         mem_q[memAddr] <= memData;
      end
   end

   // Read ports. Each port compares against the writeback address so data
   // written this cycle is forwarded, and that same match cancels the hazard
   // because the consumer is receiving the value it was waiting for.
   for (genvar g = 0; g < NUM_RD; g++) begin : gRead
      logic [ADDR_WIDTH-1:0] rdAddr;
      logic                  bypassHit;
      logic                  isZeroReg;

      assign rdAddr    = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign bypassHit = wena && (waddr == rdAddr);
`ifdef REG_FILE_ZERO_REG_EN
      assign isZeroReg = (rdAddr == '0);
`else
      assign isZeroReg = 1'b0;
`endif

      assign rdata[g*DATA_WIDTH +: DATA_WIDTH] =
         (!running || isZeroReg) ? '0 :
         bypassHit               ? wdata :
                                   mem_q[rdAddr];

      assign rd_pend[g] = running && !isZeroReg && pend_q[rdAddr] && !bypassHit;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Self-checking bench for reg_file_sb (DATA_WIDTH=64, ADDR_WIDTH=4, NUM_RD=2).
// A behavioural model (array of register values, pending bit vector and a
// count of clear edges still outstanding) predicts every output mid-cycle.
// Honours REG_FILE_ZERO_REG_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

   localparam int DW    = 64;
   localparam int AW    = 4;
   localparam int NR    = 2;
   localparam int DEPTH = 16;

`ifdef REG_FILE_ZERO_REG_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              wena;
   logic [AW-1:0]     waddr;
   logic [DW-1:0]     wdata;
   logic [NR*AW-1:0]  raddr;
   logic [NR*DW-1:0]  rdata;
   logic              pend_set;
   logic [AW-1:0]     pend_addr;
   logic [NR-1:0]     rd_pend;
   logic [DEPTH-1:0]  pend;
   logic              init_busy;

   logic [DW-1:0]     mdlMem [DEPTH];
   logic [DEPTH-1:0]  mdlPend;
   int                initLeft;
   int                checks = 0;
   int                errors = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
      .clk(clk), .rst(rst), .wena(wena), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .pend_set(pend_set), .pend_addr(pend_addr),
      .rd_pend(rd_pend), .pend(pend), .init_busy(init_busy)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] expData(input logic [AW-1:0] a);
      if (initLeft != 0)          return '0;
      if (ZERO_EN && a == 0)      return '0;
      if (wena && waddr == a)     return wdata;
      return mdlMem[a];
   endfunction

   function automatic logic expHazard(input logic [AW-1:0] a);
      if (initLeft != 0)          return 1'b0;
      if (ZERO_EN && a == 0)      return 1'b0;
      return mdlPend[a] && !(wena && waddr == a);
   endfunction

   task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic [AW-1:0] ra0,
                                input logic [AW-1:0] ra1, input logic ps, input logic [AW-1:0] pa);
      rst       = r;
      wena      = we;
      waddr     = wa;
      wdata     = wd;
      raddr     = {ra1, ra0};
      pend_set  = ps;
      pend_addr = pa;
   endtask

   task automatic checkOutput();
      check("init_busy", DW'(init_busy), DW'(initLeft != 0));
      check("pend", DW'(pend), DW'(mdlPend));
      for (int i = 0; i < NR; i++) begin
         logic [AW-1:0] a;
         a = raddr[i*AW +: AW];
         check($sformatf("rdata%0d@%0d", i, a), rdata[i*DW +: DW], expData(a));
         check($sformatf("rd_pend%0d@%0d", i, a), DW'(rd_pend[i]), DW'(expHazard(a)));
      end
   endtask

   // Advance the model across one rising edge using the inputs being held.
   task automatic modelEdge();
      if (rst) begin
         initLeft = DEPTH;
         mdlPend  = '0;
      end else if (initLeft != 0) begin
         initLeft--;
         if (initLeft == 0) begin
            for (int k = 0; k < DEPTH; k++) mdlMem[k] = '0;
         end
      end else begin
         if (wena) begin
            if (!(ZERO_EN && waddr == 0)) mdlMem[waddr] = wdata;
            mdlPend[waddr] = 1'b0;
         end
         if (pend_set && !(ZERO_EN && pend_addr == 0)) mdlPend[pend_addr] = 1'b1;
      end
   endtask

   task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra0,
                       input logic [AW-1:0] ra1, input logic ps, input logic [AW-1:0] pa);
      applyStimulus(r, we, wa, wd, ra0, ra1, ps, pa);
      #1;
      checkOutput();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic randomStep(input logic r);
      step(r, 1'(($urandom % 2)), AW'($urandom), {$urandom, $urandom},
           AW'($urandom), AW'($urandom), 1'(($urandom % 2)), AW'($urandom));
   endtask

   initial begin
      initLeft = DEPTH;
      mdlPend  = '0;
      for (int k = 0; k < DEPTH; k++) mdlMem[k] = '0;

      // First reset edge: nothing is observable before it.
      applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, '0);
      @(posedge clk);
      modelEdge();
      #1;
      $display("[TB] reset held");
      step(1'b1, 1'b0, '0, '0, 4'd1, 4'd2, 1'b0, '0);

      // Clear sequence with random writes/issues that must be ignored.
      for (int e = 0; e < DEPTH; e++) begin
         check("busy_during_init", DW'(init_busy), DW'(1));
         randomStep(1'b0);
      end
      check("busy_fell", DW'(init_busy), DW'(0));
      check("pend_after_init", DW'(pend), DW'(16'h0000));

      // Every address reads zero after clear.
      for (int a = 0; a < DEPTH; a += 2) begin
         step(1'b0, 1'b0, '0, '0, AW'(a), AW'(a + 1), 1'b0, '0);
      end

      // Write then read on both ports.
      step(1'b0, 1'b1, 4'd3, 64'hDEAD_BEEF_0000_0001, 4'd0, 4'd1, 1'b0, '0);
      step(1'b0, 1'b0, '0, '0, 4'd3, 4'd3, 1'b0, '0);
      check("wr3_port0", rdata[0 +: DW], 64'hDEAD_BEEF_0000_0001);
      check("wr3_port1", rdata[DW +: DW], 64'hDEAD_BEEF_0000_0001);

      // Bypass with a pending destination.
      step(1'b0, 1'b1, 4'd5, 64'h11, 4'd0, 4'd0, 1'b1, 4'd5);
      applyStimulus(1'b0, 1'b1, 4'd5, 64'h22, 4'd5, 4'd3, 1'b0, '0);
      #1;
      check("bypass_data", rdata[0 +: DW], 64'h22);
      check("bypass_no_hazard", DW'(rd_pend[0]), DW'(0));
      check("bypass_pend5_set", DW'(pend[5]), DW'(1));
      step(1'b0, 1'b1, 4'd5, 64'h22, 4'd5, 4'd3, 1'b0, '0);

      // Scoreboard set, hazard, clear, and set-wins collision.
      step(1'b0, 1'b0, '0, '0, 4'd7, 4'd7, 1'b1, 4'd7);
      step(1'b0, 1'b0, '0, '0, 4'd7, 4'd6, 1'b0, '0);
      check("hazard7", DW'(rd_pend[0]), DW'(1));
      step(1'b0, 1'b1, 4'd7, 64'h77, 4'd7, 4'd7, 1'b0, '0);
      check("pend7_cleared", DW'(pend[7]), DW'(0));
      step(1'b0, 1'b0, '0, '0, 4'd7, 4'd7, 1'b1, 4'd7);
      step(1'b0, 1'b1, 4'd7, 64'h78, 4'd7, 4'd1, 1'b1, 4'd7);
      check("pend7_set_wins", DW'(pend[7]), DW'(1));
      step(1'b0, 1'b1, 4'd2, 64'h2, 4'd7, 4'd2, 1'b1, 4'd9);

      // Register 0 behaviour depends on the build option.
      step(1'b0, 1'b1, 4'd0, 64'hFF, 4'd1, 4'd1, 1'b1, 4'd0);
      step(1'b0, 1'b0, '0, '0, 4'd0, 4'd0, 1'b0, '0);
      check("reg0_read", rdata[0 +: DW], ZERO_EN ? 64'h0 : 64'hFF);
      check("reg0_pend", DW'(pend[0]), DW'(!ZERO_EN));

      // Random traffic.
      for (int n = 0; n < 300; n++) randomStep(1'b0);

      // Mid-operation reset with pend = 0x00F0.
      for (int a = 0; a < DEPTH; a++) begin
         step(1'b0, 1'b1, AW'(a), {$urandom, $urandom}, AW'(a), '0, 1'b0, '0);
      end
      for (int a = 4; a < 8; a++) step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, AW'(a));
      step(1'b0, 1'b0, '0, '0, 4'd4, 4'd5, 1'b0, '0);
      check("pend_F0", DW'(pend), DW'(16'h00F0));
      step(1'b1, 1'b1, 4'd4, 64'h44, 4'd4, 4'd5, 1'b1, 4'd3);
      check("midrst_pend", DW'(pend), DW'(0));
      check("midrst_busy", DW'(init_busy), DW'(1));
      for (int e = 0; e < DEPTH; e++) randomStep(1'b0);
      for (int a = 0; a < DEPTH; a += 2) begin
         step(1'b0, 1'b0, '0, '0, AW'(a), AW'(a + 1), 1'b0, '0);
      end
      for (int n = 0; n < 100; n++) randomStep(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
